// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first.
// Subtraction uses nine's complement of B with an initial carry of one.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  err
);

    // state | meaning
    // IDLE  | waiting for start; result/cout/err hold last operation
    // CALC  | one digit processed per edge, LSD first
    // DONE  | single cycle, done pulse, result valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t              state;
    state_t              stateNext;
    logic [IW-1:0]       digitIdx;
    logic [4*DIGITS-1:0] aLatch;
    logic [4*DIGITS-1:0] bLatch;
    logic                opLatch;
    logic                carry;

    logic [3:0]          aDigit;
    logic [3:0]          bDigit;
    logic [3:0]          bTerm;
    logic [4:0]          digitSum;
    logic [4:0]          digitAdj;
    logic [3:0]          digitOut;
    logic                carryOut;
    logic                lastDigit;
    logic                anyBad;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = CALC;
            CALC:    if (lastDigit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        aDigit    = aLatch[4*digitIdx +: 4];
        bDigit    = bLatch[4*digitIdx +: 4];
        bTerm     = opLatch ? (4'd9 - bDigit) : bDigit;
        digitSum  = {1'b0, aDigit} + {1'b0, bTerm} + {4'b0000, carry};
        digitAdj  = digitSum - 5'd10;
        carryOut  = (digitSum > 5'd9);
        digitOut  = carryOut ? digitAdj[3:0] : digitSum[3:0];
        lastDigit = (digitIdx == LAST_IDX);
    end

    always_comb begin
        anyBad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (aLatch[4*i +: 4] > 4'd9 || bLatch[4*i +: 4] > 4'd9) begin
                anyBad = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            err      <= 1'b0;
            digitIdx <= '0;
            aLatch   <= '0;
            bLatch   <= '0;
            opLatch  <= 1'b0;
            carry    <= 1'b0;
        end else begin
            busy <= (stateNext == CALC);
            done <= (stateNext == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        aLatch   <= a;
                        bLatch   <= b;
                        opLatch  <= op;
                        carry    <= op;
                        digitIdx <= '0;
                        result   <= '0;
                        cout     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                CALC: begin
                    result[4*digitIdx +: 4] <= digitOut;
                    carry                   <= carryOut;
                    digitIdx                <= digitIdx + 1'b1;
                    if (lastDigit) begin
                        digitIdx <= '0;
                        // Invalid digits override whatever the adder produced.
                        if (anyBad) begin
                            result <= '0;
                            cout   <= 1'b0;
                            err    <= 1'b1;
                        end else begin
                            cout <= opLatch ? ~carryOut : carryOut;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub (DIGITS=4): driver queues expected
// results, a negedge monitor checks each done pulse against the queue.
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         Clock  = 1'b0;
    logic         Resetn = 1'b0;
    logic         start  = 1'b0;
    logic         op     = 1'b0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         err;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .err    (err)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         er;
        int           startCyc;
        int           id;
    } exp_t;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   doneSeen    = 0;
    int   pushed      = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (Resetn && done === 1'b1) begin
            doneSeen++;
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk($sformatf("v%0d_result", e.id), 32'(result), 32'(e.res));
                chk($sformatf("v%0d_cout", e.id), 32'(cout), 32'(e.co));
                chk($sformatf("v%0d_err", e.id), 32'(err), 32'(e.er));
                chk($sformatf("v%0d_latency", e.id), 32'(cyc - e.startCyc), 32'(DIGITS));
                chk($sformatf("v%0d_busy_in_done", e.id), 32'(busy), 32'd0);
            end
        end
    end

    task automatic pushExp(input logic [W-1:0] er, input logic ec, input logic ee);
        exp_t e;
        e.res      = er;
        e.co       = ec;
        e.er       = ee;
        e.startCyc = cyc + 1;
        e.id       = pushed;
        expQ.push_back(e);
        pushed++;
    endtask

    task automatic waitDone(input string name);
        for (int t = 0; t < 20 && done !== 1'b1; t++) @(negedge Clock);
        if (done !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
        end
    endtask

    // Called at a negedge; returns at the IDLE negedge right after DONE.
    task automatic runOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic o,
                         input logic [W-1:0] er, input logic ec, input logic ee);
        a = av; b = bv; op = o; start = 1'b1;
        pushExp(er, ec, ee);
        @(negedge Clock);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("result_cleared", 32'(result), 32'd0);
        a = ~av; b = ~bv; op = ~o;
        waitDone("op");
        @(negedge Clock);
        chk("hold_result", 32'(result), 32'(er));
        chk("hold_cout", 32'(cout), 32'(ec));
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        @(negedge Clock);
        Resetn = 1'b1;
        runOp(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp(16'h0500, 16'h0001, 1'b1, 16'h0499, 1'b0, 1'b0);
        runOp(16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b1, 1'b0);
        runOp(16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
        runOp(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        runOp(16'h4321, 16'h1234, 1'b1, 16'h3087, 1'b0, 1'b0);
        runOp(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
        runOp(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);
        runOp(16'h0001, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1);
        runOp(16'h2468, 16'h1357, 1'b0, 16'h3825, 1'b0, 1'b0);

        // Second start two cycles into CALC must be ignored.
        a = 16'h0250; b = 16'h0125; op = 1'b0; start = 1'b1;
        pushExp(16'h0375, 1'b0, 1'b0);
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        a = 16'h9999; b = 16'h9999; op = 1'b1; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        waitDone("busy_start");
        @(negedge Clock);
        chk("busy_start_hold", 32'(result), 32'h0375);
        repeat (8) @(negedge Clock);
        chk("busy_start_idle", 32'(busy), 32'd0);

        // Reset two cycles into CALC aborts with no done.
        a = 16'h1111; b = 16'h2222; op = 1'b0; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        runOp(16'h0789, 16'h0123, 1'b0, 16'h0912, 1'b0, 1'b0);
        runOp(16'h0100, 16'h0999, 1'b1, 16'h9101, 1'b1, 1'b0);

        repeat (10) @(negedge Clock);
        chk("done_count", 32'(doneSeen), 32'(pushed));
        chk("queue_empty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
